// File: rtl/data_mem_ctrl.sv
// MIPS data memory with valid/ready requests, byte/half/word lane merging,
// sign/zero-extended sub-word loads, fault responses and configurable read latency.
module data_mem_ctrl #(
    parameter int RAM_WORDS    = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [31:0]       mem [RAM_WORDS];

    logic              accept;
    logic              fault;
    logic              wr_commit;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wlanes;

    logic [31:0]       rword_p0;
    logic [1:0]        lane_p0;
    logic [1:0]        size_p0;
    logic              uns_p0;
    logic              err_p0;

    function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
        logic f;
        f = ({2'b00, a[31:2]} >= 32'(RAM_WORDS));
        case (sz)
            2'b01:   f = f | a[0];
            2'b10:   f = f | (a[1:0] != 2'b00);
            2'b11:   f = 1'b1;
            default: f = f;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Right-aligned store data is replicated so every candidate lane carries it.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign accept    = req_valid && req_ready;
    assign fault     = is_fault(req_size, req_addr);
    assign wr_commit = accept && req_wr && !fault;
    assign idx       = req_addr[IDX_W+1:2];
    assign be        = store_be(req_size, req_addr[1:0]);
    assign wlanes    = store_lanes(req_size, req_wdata);

    // Stores commit at the acceptance edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end

    // Stage p0: load word and access attributes captured at acceptance.
    always_ff @(posedge clk) begin
        if (accept && !req_wr) begin
            rword_p0 <= mem[idx];
            lane_p0  <= req_addr[1:0];
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            err_p0   <= fault;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (req_wr) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= fault;
                        end else begin
                            state <= WAIT;
                            cnt   <= 2'(READ_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_p0;
                        resp_rdata <= err_p0 ? 32'd0
                                             : load_extract(rword_p0, size_p0, lane_p0, uns_p0);
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances with READ_LATENCY 1, 3 and 4.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst4;
    logic        v1, v3, v4;
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;

    logic        rdy1, rv1, er1, rdy3, rv3, er3, rdy4, rv4, er4;
    logic [31:0] rd1, rd3, rd4;

    int          sel;
    logic        rdy_s, rv_s, er_s;
    logic [31:0] rd_s;

    int tests = 0;
    int fails = 0;

    data_mem_ctrl #(.RAM_WORDS(256), .READ_LATENCY(1)) u1 (
        .clk(clk), .reset(rst_a), .req_valid(v1), .req_ready(rdy1), .req_wr(wr),
        .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1));

    data_mem_ctrl #(.RAM_WORDS(256), .READ_LATENCY(3)) u3 (
        .clk(clk), .reset(rst_a), .req_valid(v3), .req_ready(rdy3), .req_wr(wr),
        .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));

    data_mem_ctrl #(.RAM_WORDS(256), .READ_LATENCY(4)) u4 (
        .clk(clk), .reset(rst4), .req_valid(v4), .req_ready(rdy4), .req_wr(wr),
        .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv4), .resp_rdata(rd4), .resp_err(er4));

    always_comb begin
        case (sel)
            3:       begin rdy_s = rdy3; rv_s = rv3; er_s = er3; rd_s = rd3; end
            4:       begin rdy_s = rdy4; rv_s = rv4; er_s = er4; rd_s = rd4; end
            default: begin rdy_s = rdy1; rv_s = rv1; er_s = er1; rd_s = rd1; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, o, e);
        end
    endtask

    task automatic set_valid(input int s, input logic v);
        case (s)
            3:       v3 = v;
            4:       v4 = v;
            default: v1 = v;
        endcase
    endtask

    // One request: lat counts edges after acceptance until resp_valid is seen.
    task automatic op(input string tag, input int s, input logic w, input logic [1:0] z,
                      input logic u, input logic [31:0] a, input logic [31:0] d,
                      input bit hold, input logic [31:0] exp_r, input logic exp_e,
                      input int exp_l);
        int n;
        int l;
        logic bad_rdy;
        logic [31:0] r;
        logic e;
        sel = s;
        @(negedge clk);
        n = 0;
        while (!rdy_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        wr = w; sz = z; uns = u; addr = a; wdata = d;
        set_valid(s, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_valid(s, 1'b0);
        l = 0;
        bad_rdy = 1'b0;
        while (!rv_s && l < 12) begin
            if (rdy_s) bad_rdy = 1'b1;
            @(posedge clk);
            #1;
            l++;
        end
        if (rdy_s) bad_rdy = 1'b1;
        r = rd_s;
        e = er_s;
        set_valid(s, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_lat"}, 32'(l), 32'(exp_l));
        chk({tag, "_rdata"}, r, exp_r);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
        chk({tag, "_busy_ready"}, {31'd0, bad_rdy}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, rdy_s}, 32'd1);
        chk({tag, "_valid_after"}, {31'd0, rv_s}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic dup;
        sel = 1;
        rst_a = 1'b0; rst4 = 1'b0;
        v1 = 1'b0; v3 = 1'b0; v4 = 1'b0;
        wr = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, rdy1}, 32'd0);
        chk("rst_valid", {31'd0, rv1}, 32'd0);
        chk("rst_rdata", rd1, 32'd0);
        chk("rst_err", {31'd0, er1}, 32'd0);
        chk("rst_ready_u4", {31'd0, rdy4}, 32'd0);

        @(negedge clk);
        rst_a = 1'b1; rst4 = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", {31'd0, rdy1}, 32'd1);

        op("sw_10",  1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 0);
        op("lw_10",  1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0, 1);
        op("sb_12",  1, 1, 2'b00, 0, 32'h12, 32'h12345680, 0, 32'h0,        0, 0);
        op("lb_12",  1, 0, 2'b00, 0, 32'h12, 32'h0,        0, 32'hFFFFFF80, 0, 1);
        op("lbu_12", 1, 0, 2'b00, 1, 32'h12, 32'h0,        0, 32'h00000080, 0, 1);
        op("lw_10b", 1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDE80BEEF, 0, 1);

        op("sw_14",  1, 1, 2'b10, 0, 32'h14, 32'h11223344, 0, 32'h0,        0, 0);
        op("sh_16",  1, 1, 2'b01, 0, 32'h16, 32'hAAAA8001, 0, 32'h0,        0, 0);
        op("lw_14",  1, 0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h80013344, 0, 1);
        op("lh_16",  1, 0, 2'b01, 0, 32'h16, 32'h0,        0, 32'hFFFF8001, 0, 1);
        op("lhu_16", 1, 0, 2'b01, 1, 32'h16, 32'h0,        0, 32'h00008001, 0, 1);
        op("lh_14",  1, 0, 2'b01, 0, 32'h14, 32'h0,        0, 32'h00003344, 0, 1);
        op("lb_15",  1, 0, 2'b00, 0, 32'h15, 32'h0,        0, 32'h00000033, 0, 1);

        op("sw_mis", 1, 1, 2'b10, 0, 32'h11, 32'hFFFFFFFF, 0, 32'h0,        1, 0);
        op("lw_chk", 1, 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDE80BEEF, 0, 1);
        op("lh_mis", 1, 0, 2'b01, 0, 32'h13, 32'h0,        0, 32'h0,        1, 1);
        op("lw_oor", 1, 0, 2'b10, 0, 32'h400, 32'h0,       0, 32'h0,        1, 1);
        op("lw_hi",  1, 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,  0, 32'h0,        1, 1);
        op("ld_sz3", 1, 0, 2'b11, 0, 32'h10, 32'h0,        0, 32'h0,        1, 1);
        op("st_sz3", 1, 1, 2'b11, 0, 32'h14, 32'hFFFFFFFF, 0, 32'h0,        1, 0);
        op("lw_14b", 1, 0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h80013344, 0, 1);
        op("sw_top", 1, 1, 2'b10, 0, 32'h3FC, 32'h0BADF00D, 0, 32'h0,       0, 0);
        op("lw_top", 1, 0, 2'b10, 0, 32'h3FC, 32'h0,       0, 32'h0BADF00D, 0, 1);
        op("sb_oor", 1, 1, 2'b00, 0, 32'h400, 32'h55,      0, 32'h0,        1, 0);

        op("sw3_20",  3, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0,        0, 0);
        op("lw3_20",  3, 0, 2'b10, 0, 32'h20, 32'h0,        1, 32'hCAFEF00D, 0, 3);
        dup = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rv3) dup = 1'b1;
        end
        chk("lw3_no_dup", {31'd0, dup}, 32'd0);
        op("lbu3_23", 3, 0, 2'b00, 1, 32'h23, 32'h0,        0, 32'h000000CA, 0, 3);

        op("sw4_40",  4, 1, 2'b10, 0, 32'h40, 32'h5A5A5A5A, 0, 32'h0,        0, 0);
        sel = 4;
        @(negedge clk);
        wr = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h40;
        v4 = 1'b1;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst4 = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, rdy4}, 32'd0);
        chk("midrst_valid", {31'd0, rv4}, 32'd0);
        chk("midrst_rdata", rd4, 32'd0);
        chk("midrst_err", {31'd0, er4}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        dup = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rv4) dup = 1'b1;
        end
        chk("midrst_no_resp", {31'd0, dup}, 32'd0);
        chk("midrst_ready_after", {31'd0, rdy4}, 32'd1);
        op("lw4_40",  4, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h5A5A5A5A, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
